// File: rtl/ch0re_ifetch_pkg.sv
// Shared types for the ch0re instruction fetch stage.
// Holds the fetch FSM encoding, the buffered fetch entry layout and the default NOP word.
package ch0re_types;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // ADDI x0,x0,0

  typedef enum logic [1:0] {
    IFS_IDLE,
    IFS_RUN,
    IFS_HALT
  } ifetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ch0re_fetch_fifo.sv
// Small synchronous FIFO for fetched {instr, pc} words.
// Flush empties it in one cycle. The head entry is read straight from the storage registers.
module ch0re_fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register here sample pre-edge values.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage has no reset; the count gates validity, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign count = cnt;

endmodule

// File: rtl/ch0re_ifetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads over req/gnt/rvalid,
// buffers returned words and hands one {instr, pc} per cycle to decode.
module ch0re_ifetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = ch0re_types::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc,
  input  logic        i_pl_stall,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [63:0] o_pc,
  output logic        o_fetch_misaligned
);

  import ch0re_types::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifetch_state_e state_q, state_d;
  logic [63:0]   fetch_pc;
  logic [63:0]   req_pc;
  logic          outstanding;
  logic          drop;
  logic          misaligned;

  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          issue;
  logic          fire;
  logic          redirect_bad;

  assign redirect_bad = (i_redirect_pc[1:0] != 2'b00);

  // Buffered words plus the one in flight must fit in the FIFO before a new read goes out.
  assign credit_used = (CW+1)'(count) + (CW+1)'(outstanding);
  assign issue       = (state_q == IFS_RUN) && !outstanding
                    && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign fire        = issue && i_imem_gnt;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IFS_IDLE: state_d = (i_redirect && redirect_bad) ? IFS_HALT : IFS_RUN;
      IFS_RUN:  if (i_redirect && redirect_bad)  state_d = IFS_HALT;
      IFS_HALT: if (i_redirect && !redirect_bad) state_d = IFS_RUN;
      default:  state_d = IFS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IFS_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      misaligned  <= 1'b0;
    end else if (i_redirect) begin
      // Anything still owed by memory (including a read granted right now) belongs to the old path.
      fetch_pc    <= i_redirect_pc;
      outstanding <= (outstanding && !i_imem_rvalid) || fire;
      drop        <= (outstanding && !i_imem_rvalid) || fire;
      misaligned  <= redirect_bad;
    end else begin
      if (i_imem_rvalid) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
      if (fire) begin
        fetch_pc    <= fetch_pc + 64'd4;
        req_pc      <= fetch_pc;
        outstanding <= 1'b1;
      end
    end
  end

  assign push_entry = '{instr: i_imem_rdata, pc: req_pc};
  assign fifo_push  = i_imem_rvalid && !drop && !i_redirect;
  assign fifo_pop   = !fifo_empty && !i_pl_stall;

  ch0re_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (i_redirect),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count)
  );

  assign o_imem_req         = issue;
  assign o_imem_addr        = {fetch_pc[63:2], 2'b00};
  assign o_valid            = !fifo_empty;
  assign o_instr            = fifo_empty ? NOP_INSTR : head_entry.instr;
  assign o_pc               = fifo_empty ? fetch_pc  : head_entry.pc;
  assign o_fetch_misaligned = misaligned;

  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule

// File: tb/tb_ch0re_ifetch.sv
// Self-checking bench for ch0re_ifetch: directed scenarios then randomized traffic,
// all compared against a transaction-level model (epoch-tagged reads and an output queue).
module tb_ch0re_ifetch;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        pl_stall;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [63:0] o_pc;
  logic        o_fetch_misaligned;

  always #5 clk = ~clk;

  ch0re_ifetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .o_imem_req         (imem_req),
    .o_imem_addr        (imem_addr),
    .i_imem_gnt         (imem_gnt),
    .i_imem_rvalid      (imem_rvalid),
    .i_imem_rdata       (imem_rdata),
    .i_redirect         (redirect),
    .i_redirect_pc      (redirect_pc),
    .i_pl_stall         (pl_stall),
    .o_valid            (o_valid),
    .o_instr            (o_instr),
    .o_pc               (o_pc),
    .o_fetch_misaligned (o_fetch_misaligned)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  int tests = 0;
  int fails = 0;

  // Reference model: expected decode-visible queue, memory-side pending read, fetch address stream.
  exp_t        q[$];
  bit          pending;
  logic [63:0] pend_addr;
  int          pend_cnt;
  int          pend_tag;
  int          epoch;
  logic [63:0] exp_pc;
  bit          halt;
  bit          idle;

  int          gnt_pct = 100;
  int          lat_lo  = 1;
  int          lat_hi  = 1;
  bit          arm_gnt, arm_rv, fired;
  logic [63:0] arm_addr, arm_pc;

  function automatic logic [31:0] mem_word(logic [63:0] a);
    if (a == 64'h0) return 32'h0050_0093;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit redir_in, input logic [63:0] rpc_in, input bit stall_in);
    bit          rv, gn, rd, kept, exp_req;
    logic [63:0] rp;
    int          old_epoch;
    @(negedge clk);
    exp_req = !idle && !halt && !pending && (q.size() + int'(pending) < DEPTH);
    check("req", {95'b0, imem_req}, {95'b0, exp_req});
    rv = pending && (pend_cnt == 0);
    gn = imem_req && !pending && ($urandom_range(0, 99) < gnt_pct);
    rd = redir_in;
    rp = rpc_in;
    if (arm_gnt && gn && imem_addr == arm_addr) begin
      rd = 1'b1; rp = arm_pc; arm_gnt = 1'b0; fired = 1'b1;
    end
    if (arm_rv && rv) begin
      rd = 1'b1; rp = arm_pc; arm_rv = 1'b0; fired = 1'b1;
    end
    imem_gnt    = gn;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend_addr) : $urandom();
    redirect    = rd;
    redirect_pc = rp;
    pl_stall    = stall_in;
    if (gn) check("addr", {32'b0, imem_addr}, {32'b0, exp_pc});
    @(posedge clk);
    #1;
    old_epoch = epoch;
    kept = rv && (pend_tag == epoch) && !rd;
    if (rv) pending = 1'b0;
    if (rd) begin
      q.delete();
      epoch++;
      halt = (rp[1:0] != 2'b00);
    end else begin
      if (q.size() > 0 && !stall_in) void'(q.pop_front());
      if (kept) q.push_back('{instr: mem_word(pend_addr), pc: pend_addr});
    end
    if (gn) begin
      pending  = 1'b1;
      pend_addr = exp_pc;
      pend_tag = old_epoch;
      pend_cnt = $urandom_range(lat_lo, lat_hi) - 1;
    end else if (pending) begin
      pend_cnt--;
    end
    if (rd)      exp_pc = rp;
    else if (gn) exp_pc = exp_pc + 64'd4;
    idle = 1'b0;
    check("valid", {95'b0, o_valid}, {95'b0, q.size() > 0});
    if (q.size() > 0) begin
      check("instr", {64'b0, o_instr}, {64'b0, q[0].instr});
      check("pc", {32'b0, o_pc}, {32'b0, q[0].pc});
    end else begin
      check("nop", {64'b0, o_instr}, {64'b0, NOP});
    end
    check("misaligned", {95'b0, o_fetch_misaligned}, {95'b0, halt});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; pl_stall = 1'b0;
    #1;
    check("rst_req", {95'b0, imem_req}, 96'd0);
    check("rst_addr", {32'b0, imem_addr}, {32'b0, RESET_PC});
    check("rst_valid", {95'b0, o_valid}, 96'd0);
    check("rst_instr", {64'b0, o_instr}, {64'b0, NOP});
    check("rst_pc", {32'b0, o_pc}, {32'b0, RESET_PC});
    check("rst_misaligned", {95'b0, o_fetch_misaligned}, 96'd0);
    q.delete();
    pending = 1'b0; pend_cnt = 0; epoch++;
    exp_pc = RESET_PC; halt = 1'b0;
    arm_gnt = 1'b0; arm_rv = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    idle = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] seen[$];
    int          n;
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; pl_stall = 1'b0;
    epoch = 0; idle = 1'b1; pend_addr = '0; pend_tag = 0;

    // First fetch, then stall until the FIFO fills and issue stops.
    do_reset();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    repeat (8) cycle(1'b0, 64'h0, 1'b1);
    check("t2_full_req", {95'b0, imem_req}, 96'd0);
    check("t2_head_valid", {95'b0, o_valid}, 96'd1);
    check("t2_head_instr", {64'b0, o_instr}, 96'h0050_0093);
    check("t2_head_pc", {32'b0, o_pc}, 96'h0);

    // Release the stall: consumed PCs must be 0,4,8,... with none skipped or repeated.
    for (int i = 0; i < 16; i++) begin
      if (o_valid) seen.push_back(o_pc);
      cycle(1'b0, 64'h0, 1'b0);
    end
    check("t2_enough", {95'b0, seen.size() >= 6}, 96'd1);
    for (int i = 0; i < seen.size(); i++) check("t2_seq", {32'b0, seen[i]}, 96'(4 * i));

    // Redirect in the grant cycle of 0x8; the late word must vanish.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    fired = 1'b0; arm_gnt = 1'b1; arm_addr = 64'h8; arm_pc = 64'h100;
    n = 0;
    while (!fired && n < 40) begin cycle(1'b0, 64'h0, 1'b0); n++; end
    check("t3_fired", {95'b0, fired}, 96'd1);
    n = 0;
    while (!o_valid && n < 40) begin cycle(1'b0, 64'h0, 1'b0); n++; end
    check("t3_valid", {95'b0, o_valid}, 96'd1);
    check("t3_pc", {32'b0, o_pc}, 96'h100);
    check("t3_instr", {64'b0, o_instr}, {64'b0, mem_word(64'h100)});

    // Redirect coinciding with rvalid.
    lat_lo = 1; lat_hi = 2;
    fired = 1'b0; arm_rv = 1'b1; arm_pc = 64'h40;
    n = 0;
    while (!fired && n < 40) begin cycle(1'b0, 64'h0, 1'b0); n++; end
    check("t4_fired", {95'b0, fired}, 96'd1);
    check("t4_valid", {95'b0, o_valid}, 96'd0);
    check("t4_instr", {64'b0, o_instr}, {64'b0, NOP});

    // Misaligned redirect halts fetch until an aligned one arrives.
    cycle(1'b1, 64'h102, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 64'h0, 1'b0);
      check("t5_halt_req", {95'b0, imem_req}, 96'd0);
      check("t5_flag", {95'b0, o_fetch_misaligned}, 96'd1);
    end
    cycle(1'b1, 64'h200, 1'b0);
    check("t5_flag_clear", {95'b0, o_fetch_misaligned}, 96'd0);
    n = 0;
    while (!imem_req && n < 20) begin cycle(1'b0, 64'h0, 1'b0); n++; end
    check("t5_req", {95'b0, imem_req}, 96'd1);
    check("t5_addr", {32'b0, imem_addr}, 96'h200);

    // Reset with a read in flight.
    lat_lo = 3; lat_hi = 3;
    n = 0;
    while (!pending && n < 20) begin cycle(1'b0, 64'h0, 1'b0); n++; end
    check("t6_pending", {95'b0, pending}, 96'd1);
    do_reset();
    n = 0;
    while (!imem_req && n < 10) begin cycle(1'b0, 64'h0, 1'b0); n++; end
    check("t6_req", {95'b0, imem_req}, 96'd1);
    check("t6_addr", {32'b0, imem_addr}, {32'b0, RESET_PC});

    // Randomized traffic: grant gaps, variable latency, stalls, redirects (some misaligned, some near wrap).
    for (int i = 0; i < 3000; i++) begin
      bit          rdr;
      logic [63:0] tgt;
      if (i % 300 == 0) begin
        gnt_pct = $urandom_range(30, 100);
        lat_lo  = 1;
        lat_hi  = $urandom_range(1, 4);
      end
      if (i == 1500) do_reset();
      rdr = !idle && ($urandom_range(0, 99) < 4);
      tgt = 64'($urandom_range(0, 1023)) * 64'd4;
      if ($urandom_range(0, 9) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0;
      if ($urandom_range(0, 9) == 0) tgt = tgt + 64'd2;
      cycle(rdr, tgt, $urandom_range(0, 99) < 30);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
